// File: rtl/microsequencer.sv
// Microcode sequencer: walks a registered microcode ROM through fetch, opcode
// dispatch and stall cycles, halting on the all-ones halt word.
module microsequencer #(
  parameter int unsigned OFFSET_WIDTH = 6,
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter int unsigned ICOUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mc_seq,
  input  logic [OFFSET_WIDTH-1:0] mc_next,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    branch_cond,
  input  logic                    mem_wait,
  input  logic                    resume,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic [OFFSET_WIDTH-1:0] upc,
  output logic                    halted,
  output logic                    illegal_op,
  output logic [ICOUNT_WIDTH-1:0] icount
);

  localparam logic [OFFSET_WIDTH-1:0] OFF_ONES    = '1;
  localparam logic [OPCODE_WIDTH-1:0] LAST_LEGAL  = OPCODE_WIDTH'(17);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [OFFSET_WIDTH-1:0] upc_nxt;
  logic [ICOUNT_WIDTH-1:0] icount_nxt;
  logic                    ill_nxt;
  logic                    halt_word;
  logic                    op_illegal;
  logic [OFFSET_WIDTH-1:0] disp_off;

  // Opcode to microroutine entry point; unmapped opcodes land on the halt word.
  function automatic logic [OFFSET_WIDTH-1:0] dispatch(
    input logic [OPCODE_WIDTH-1:0] op,
    input logic                    cond
  );
    logic [5:0] t;
    logic       hit;
    hit = 1'b1;
    t   = 6'h00;
    case (op)
      OPCODE_WIDTH'(5'h00): t = 6'h02;
      OPCODE_WIDTH'(5'h01): t = 6'h03;
      OPCODE_WIDTH'(5'h02): t = 6'h04;
      OPCODE_WIDTH'(5'h03): t = 6'h08;
      OPCODE_WIDTH'(5'h04): t = 6'h0A;
      OPCODE_WIDTH'(5'h05): t = 6'h0E;
      OPCODE_WIDTH'(5'h06): t = cond ? 6'h0E : 6'h0F;
      OPCODE_WIDTH'(5'h07): t = 6'h10;
      OPCODE_WIDTH'(5'h08): t = 6'h11;
      OPCODE_WIDTH'(5'h09): t = 6'h12;
      OPCODE_WIDTH'(5'h0A): t = 6'h16;
      OPCODE_WIDTH'(5'h0B): t = 6'h1A;
      OPCODE_WIDTH'(5'h0C): t = 6'h1E;
      OPCODE_WIDTH'(5'h0D): t = 6'h22;
      OPCODE_WIDTH'(5'h0E): t = 6'h26;
      OPCODE_WIDTH'(5'h0F): t = 6'h27;
      OPCODE_WIDTH'(5'h10): t = 6'h28;
      OPCODE_WIDTH'(5'h11): t = 6'h29;
      default:              hit = 1'b0;
    endcase
    return hit ? OFFSET_WIDTH'(t) : OFF_ONES;
  endfunction

  assign halt_word  = mc_seq && (mc_next == OFF_ONES);
  assign op_illegal = (opcode > LAST_LEGAL);
  assign disp_off   = dispatch(opcode, branch_cond);

  // Next-state, next micro-PC and ROM address selection.
  always_comb begin
    state_nxt  = state;
    offset     = '0;
    upc_nxt    = upc;
    icount_nxt = icount;
    ill_nxt    = illegal_op;
    case (state)
      ST_INIT: begin
        offset    = '0;
        upc_nxt   = '0;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt_word) begin
          offset    = OFF_ONES;
          state_nxt = ST_HALT;
        end else if (mem_wait) begin
          offset = upc;
        end else if (mc_seq) begin
          offset  = mc_next;
          upc_nxt = mc_next;
          // Returning to fetch from a non-fetch word retires an instruction.
          if ((mc_next == '0) && (upc != '0)) begin
            icount_nxt = icount + ICOUNT_WIDTH'(1);
          end
        end else begin
          offset  = disp_off;
          upc_nxt = disp_off;
          if (op_illegal) begin
            ill_nxt = 1'b1;
          end
        end
      end
      ST_HALT: begin
        offset = OFF_ONES;
        if (resume) begin
          state_nxt  = ST_INIT;
          icount_nxt = '0;
          ill_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      upc        <= '0;
      icount     <= '0;
      illegal_op <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      upc        <= upc_nxt;
      icount     <= icount_nxt;
      illegal_op <= ill_nxt;
      halted     <= (state_nxt == ST_HALT);
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: registered ROM model, behavioural
// reference model, directed scenarios and randomized traffic.
module tb_microsequencer;

  localparam int unsigned OW = 6;
  localparam int unsigned PW = 5;
  localparam int unsigned IW = 10;
  localparam int          ONES = 63;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mc_seq;
  logic [OW-1:0] mc_next;
  logic [PW-1:0] opcode;
  logic          branch_cond;
  logic          mem_wait;
  logic          resume;
  logic [OW-1:0] offset;
  logic [OW-1:0] upc;
  logic          halted;
  logic          illegal_op;
  logic [IW-1:0] icount;

  always #5 clk = ~clk;

  microsequencer #(.OFFSET_WIDTH(OW), .OPCODE_WIDTH(PW), .ICOUNT_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .mc_seq(mc_seq), .mc_next(mc_next), .opcode(opcode),
    .branch_cond(branch_cond), .mem_wait(mem_wait), .resume(resume), .offset(offset),
    .upc(upc), .halted(halted), .illegal_op(illegal_op), .icount(icount)
  );

  // Microcode ROM: word = {seq, next}; registered read of the presented offset.
  logic [OW:0] rom [64];
  logic [OW:0] rom_q;
  always_ff @(posedge clk) rom_q <= rom[offset];
  assign mc_seq  = rom_q[OW];
  assign mc_next = rom_q[OW-1:0];

  int errors = 0;
  int checks = 0;
  int disp_tab [32];
  int m_mode;        // 0 = INIT, 1 = RUN, 2 = HALT
  int m_upc;
  int m_icount;
  int m_ill;
  int last_off;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_disp(input int op, input int bc);
    if (op == 6) return bc ? 14 : 15;
    return disp_tab[op];
  endfunction

  function automatic int exp_offset();
    int wseq, wnext;
    if (m_mode == 0) return 0;
    if (m_mode == 2) return ONES;
    wseq  = int'(rom[m_upc][OW]);
    wnext = int'(rom[m_upc][OW-1:0]);
    if (wseq == 1 && wnext == ONES) return ONES;
    if (mem_wait) return m_upc;
    if (wseq == 1) return wnext;
    return model_disp(int'(opcode), int'(branch_cond));
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_edge();
    int wseq, wnext;
    case (m_mode)
      0: begin m_mode = 1; m_upc = 0; end
      1: begin
        wseq  = int'(rom[m_upc][OW]);
        wnext = int'(rom[m_upc][OW-1:0]);
        if (wseq == 1 && wnext == ONES) m_mode = 2;
        else if (mem_wait) begin end
        else if (wseq == 1) begin
          if (wnext == 0 && m_upc != 0) m_icount = (m_icount + 1) % (1 << IW);
          m_upc = wnext;
        end else begin
          m_upc = model_disp(int'(opcode), int'(branch_cond));
          if (int'(opcode) >= 18) m_ill = 1;
        end
      end
      default: if (resume) begin m_mode = 0; m_icount = 0; m_ill = 0; end
    endcase
  endtask

  task automatic compare_all();
    chk("offset", int'(offset), exp_offset());
    chk("upc", int'(upc), m_upc);
    chk("halted", int'(halted), (m_mode == 2) ? 1 : 0);
    chk("illegal_op", int'(illegal_op), m_ill);
    chk("icount", int'(icount), m_icount);
  endtask

  // One clock: drive inputs, compare at the falling edge, then take the rising edge.
  task automatic step(input int op, input int mw, input int bc, input int rs);
    opcode      = PW'(op);
    mem_wait    = mw[0];
    branch_cond = bc[0];
    resume      = rs[0];
    @(negedge clk);
    last_off = int'(offset);
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic stepc(input string name, input int op, input int mw, input int bc,
                       input int rs, input int exp_upc);
    step(op, mw, bc, rs);
    chk(name, int'(upc), exp_upc);
  endtask

  // Asynchronous reset pulse, called one time unit after a rising edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_offset", int'(offset), 0);
    chk("rst_upc", int'(upc), 0);
    chk("rst_icount", int'(icount), 0);
    chk("rst_illegal", int'(illegal_op), 0);
    chk("rst_halted", int'(halted), 0);
    m_mode = 0; m_upc = 0; m_icount = 0; m_ill = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    disp_tab = '{2, 3, 4, 8, 10, 14, 0, 16, 17, 18, 22, 26, 30, 34, 38, 39,
                 40, 41, 63, 63, 63, 63, 63, 63, 63, 63, 63, 63, 63, 63, 63, 63};
    for (int a = 0; a < 64; a++) rom[a] = {1'b1, 6'(a + 1)};
    foreach (disp_tab[i]) if (i == 2 || i == 3) rom[i] = {1'b1, 6'd0};
    rom[7]  = {1'b1, 6'd0};  rom[9]  = {1'b1, 6'd0};  rom[13] = {1'b1, 6'd0};
    rom[16] = {1'b1, 6'd0};  rom[17] = {1'b1, 6'd0};  rom[21] = {1'b1, 6'd0};
    rom[25] = {1'b1, 6'd0};  rom[29] = {1'b1, 6'd0};  rom[33] = {1'b1, 6'd0};
    for (int a = 37; a < 63; a++) rom[a] = {1'b1, 6'd0};
    rom[0]  = {1'b1, 6'd1};
    rom[1]  = {1'b0, 6'd0};
    rom[63] = {1'b1, 6'd63};

    rst_n = 1'b0; opcode = '0; mem_wait = 1'b0; branch_cond = 1'b0; resume = 1'b0;
    m_mode = 0; m_upc = 0; m_icount = 0; m_ill = 0; last_off = 0;
    @(posedge clk);
    #1;
    do_reset();

    // LDI after reset release
    stepc("ldi_init", 1, 0, 0, 0, 0);
    stepc("ldi_fetch", 1, 0, 0, 0, 1);
    stepc("ldi_disp", 1, 0, 0, 0, 3);
    stepc("ldi_ret", 1, 0, 0, 0, 0);
    chk("ldi_icount", int'(icount), 1);

    // LD with two stall cycles at 05
    stepc("ld_fetch", 2, 0, 0, 0, 1);
    stepc("ld_disp", 2, 0, 0, 0, 4);
    stepc("ld_05", 2, 0, 0, 0, 5);
    stepc("ld_stall1", 2, 1, 0, 0, 5);
    chk("ld_offset_stall", last_off, 5);
    stepc("ld_stall2", 2, 1, 0, 0, 5);
    chk("ld_icount_held", int'(icount), 1);
    stepc("ld_06", 2, 0, 0, 0, 6);
    stepc("ld_07", 2, 0, 0, 0, 7);
    chk("ld_icount_pre", int'(icount), 1);
    stepc("ld_ret", 2, 0, 0, 0, 0);
    chk("ld_icount", int'(icount), 2);

    // Conditional branch both ways
    stepc("br1_fetch", 6, 0, 1, 0, 1);
    stepc("br1_disp", 6, 0, 1, 0, 14);
    for (int i = 0; i < 3; i++) step(6, 0, 1, 0);
    chk("br1_back", int'(upc), 0);
    stepc("br0_fetch", 6, 0, 0, 0, 1);
    stepc("br0_disp", 6, 0, 0, 0, 15);
    for (int i = 0; i < 2; i++) step(6, 0, 0, 0);
    chk("br0_back", int'(upc), 0);

    // Illegal opcode, halt, resume
    stepc("ill_fetch", 21, 0, 0, 0, 1);
    stepc("ill_disp", 21, 0, 0, 0, 63);
    chk("ill_offset", last_off, 63);
    chk("ill_flag", int'(illegal_op), 1);
    chk("ill_not_halted_yet", int'(halted), 0);
    step(21, 1, 0, 0);
    chk("ill_halted", int'(halted), 1);
    step(21, 0, 0, 0);
    chk("halt_offset", last_off, 63);
    chk("halt_stays", int'(halted), 1);
    step(21, 0, 0, 1);
    chk("resume_ill_clr", int'(illegal_op), 0);
    chk("resume_icount_clr", int'(icount), 0);
    chk("resume_halted_clr", int'(halted), 0);
    stepc("resume_init", 1, 0, 0, 0, 0);
    stepc("resume_fetch", 1, 0, 0, 0, 1);

    // icount wrap
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int n = 0; n < (1 << IW) - 2; n++) begin
      step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    end
    chk("icount_ones", int'(icount), (1 << IW) - 1);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("icount_wrap", int'(icount), 0);

    // Reset mid-stall at 0C
    stepc("st_fetch", 4, 0, 0, 0, 1);
    stepc("st_disp", 4, 0, 0, 0, 10);
    stepc("st_0b", 4, 0, 0, 0, 11);
    stepc("st_0c", 4, 0, 0, 0, 12);
    stepc("st_stall", 4, 1, 0, 0, 12);
    do_reset();
    stepc("st_init", 4, 0, 0, 0, 0);
    stepc("st_refetch", 4, 0, 0, 0, 1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int op;
      if ($urandom_range(0, 39) == 0) op = int'($urandom_range(18, 31));
      else op = int'($urandom_range(0, 17));
      step(op, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 1 : 0);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
